// File: rtl/sys_defs.sv
// Shared bus/arbiter definitions for the memory bus arbiter slice.
package sys_defs;

  localparam int XLEN = 32;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam logic ARB_OWNER_I = 1'b0;
  localparam logic ARB_OWNER_D = 1'b1;

  typedef enum logic {
    DCACHE_PRI   = 1'b0,
    ICACHE_BOOST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic owner;
    logic stale;
  } tag_entry_t;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding memory tag table: owner/valid/stale per tag.
// Free is applied before allocate, so a same-cycle reuse keeps the new owner.
module mem_tag_table
  import sys_defs::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             alloc_owner,
  input  logic             free_en,
  input  logic [TAG_W-1:0] ret_tag,
  input  logic             flush,
  output logic             ret_valid,
  output logic             ret_owner,
  output logic             ret_stale
);

  localparam int N = 1 << TAG_W;

  tag_entry_t tbl_q [N];
  tag_entry_t tbl_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      tbl_d[i] = tbl_q[i];
      if (flush && tbl_q[i].valid &&
          tbl_q[i].owner == ARB_OWNER_I)
        tbl_d[i].stale = 1'b1;
    end
    if (free_en)
      tbl_d[ret_tag] = '0;
    if (alloc_en) begin
      tbl_d[alloc_tag].valid = 1'b1;
      tbl_d[alloc_tag].owner = alloc_owner;
      tbl_d[alloc_tag].stale = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        tbl_q[i] <= tbl_d[i];
    end
  end

  assign ret_valid = tbl_q[ret_tag].valid;
  assign ret_owner = tbl_q[ret_tag].owner;
  assign ret_stale = tbl_q[ret_tag].stale;

endmodule

// File: rtl/mem_bus_arbiter.sv
// icache/dcache memory bus arbiter with tag-based return routing.
// Define ARB_STARVE_GUARD_EN to enable the icache starvation boost.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int TAG_W        = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       icache_command,
  input  logic [XLEN-1:0]  icache_addr,
  input  logic             icache_flush,
  input  logic [1:0]       dcache_command,
  input  logic [XLEN-1:0]  dcache_addr,
  input  logic [63:0]      dcache_data,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag,
  output logic [1:0]       proc2mem_command,
  output logic [XLEN-1:0]  proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [TAG_W-1:0] icache_response,
  output logic [TAG_W-1:0] dcache_response,
  output logic [TAG_W-1:0] icache_tag,
  output logic [TAG_W-1:0] dcache_tag,
  output logic [63:0]      mem_data_out,
  output logic             grant_dcache
);

  logic            i_pend, d_pend;
  logic            grant_i, grant_d;
  logic [1:0]      cmd_w;
  logic [XLEN-1:0] addr_w;

  assign i_pend = icache_command != BUS_NONE;
  assign d_pend = dcache_command != BUS_NONE;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_TRIP =
    CNT_W'(STARVE_LIMIT - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             i_denied;

  assign grant_i = (state_q == ICACHE_BOOST) ?
                   i_pend : (i_pend && !d_pend);
  assign i_denied = i_pend && !grant_i;

  always_comb begin
    starve_d = '0;
    if (i_denied)
      starve_d = (&starve_q) ? starve_q : starve_q + 1'b1;
    state_d = DCACHE_PRI;
    if (state_q == DCACHE_PRI && i_denied &&
        starve_q == CNT_TRIP)
      state_d = ICACHE_BOOST;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= DCACHE_PRI;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
`else
  assign grant_i = i_pend && !d_pend;
`endif

  assign grant_d = d_pend && !grant_i;

  always_comb begin
    cmd_w  = BUS_NONE;
    addr_w = '0;
    if (grant_d) begin
      cmd_w  = dcache_command;
      addr_w = dcache_addr;
    end else if (grant_i) begin
      cmd_w  = icache_command;
      addr_w = icache_addr;
    end
  end

  logic alloc_en, free_en, flush;
  logic ret_valid, ret_owner, ret_stale, ret_hit;

  assign alloc_en = !reset && (mem2proc_response != '0) &&
                    cmd_w == BUS_LOAD;
  assign ret_hit  = (mem2proc_tag != '0) && ret_valid;
  assign free_en  = !reset && ret_hit;
  assign flush    = !reset && icache_flush;

  mem_tag_table #(
    .TAG_W(TAG_W)
  ) u_tag_table (
    .clock      (clock),
    .reset      (reset),
    .alloc_en   (alloc_en),
    .alloc_tag  (mem2proc_response),
    .alloc_owner(grant_d ? ARB_OWNER_D : ARB_OWNER_I),
    .free_en    (free_en),
    .ret_tag    (mem2proc_tag),
    .flush      (flush),
    .ret_valid  (ret_valid),
    .ret_owner  (ret_owner),
    .ret_stale  (ret_stale)
  );

  always_comb begin
    proc2mem_command = reset ? BUS_NONE : cmd_w;
    proc2mem_addr    = reset ? '0 : addr_w;
    icache_response  = (!reset && grant_i) ? mem2proc_response : '0;
    dcache_response  = (!reset && grant_d) ? mem2proc_response : '0;
    grant_dcache     = !reset && grant_d;
    icache_tag       = '0;
    dcache_tag       = '0;
    if (free_en) begin
      if (ret_owner == ARB_OWNER_D)
        dcache_tag = mem2proc_tag;
      else if (!ret_stale)
        icache_tag = mem2proc_tag;
    end
  end

  assign proc2mem_data = dcache_data;
  assign mem_data_out  = mem2proc_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;
  import sys_defs::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       ic_cmd, dc_cmd;
  logic [XLEN-1:0]  ic_addr, dc_addr;
  logic             ic_flush;
  logic [63:0]      dc_data, m_data;
  logic [3:0]       m_resp, m_tag;
  logic [1:0]       p_cmd;
  logic [XLEN-1:0]  p_addr;
  logic [63:0]      p_data, d_out;
  logic [3:0]       ic_resp, dc_resp, ic_tag, dc_tag;
  logic             gnt_d;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clock            (clk),
    .reset            (rst),
    .icache_command   (ic_cmd),
    .icache_addr      (ic_addr),
    .icache_flush     (ic_flush),
    .dcache_command   (dc_cmd),
    .dcache_addr      (dc_addr),
    .dcache_data      (dc_data),
    .mem2proc_response(m_resp),
    .mem2proc_data    (m_data),
    .mem2proc_tag     (m_tag),
    .proc2mem_command (p_cmd),
    .proc2mem_addr    (p_addr),
    .proc2mem_data    (p_data),
    .icache_response  (ic_resp),
    .dcache_response  (dc_resp),
    .icache_tag       (ic_tag),
    .dcache_tag       (dc_tag),
    .mem_data_out     (d_out),
    .grant_dcache     (gnt_d)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ic_cmd   = BUS_NONE;
    dc_cmd   = BUS_NONE;
    ic_addr  = '0;
    dc_addr  = '0;
    ic_flush = 1'b0;
    m_resp   = '0;
    m_tag    = '0;
  endtask

  // drive on negedge, sample 1ns later, state updates at posedge
  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst     = 1'b1;
    dc_data = 64'hDEAD_BEEF_0123_4567;
    m_data  = 64'h0;
    idle();

    nxt();
    ic_cmd = BUS_LOAD; ic_addr = 32'h100;
    dc_cmd = BUS_LOAD; dc_addr = 32'h200;
    m_resp = 4'd3; m_tag = 4'd3;
    #1;
    chk("rst_cmd", p_cmd, BUS_NONE);
    chk("rst_addr", p_addr, 0);
    chk("rst_gnt", gnt_d, 0);
    chk("rst_itag", ic_tag, 0);
    chk("rst_dtag", dc_tag, 0);
    chk("rst_iresp", ic_resp, 0);
    nxt();
    rst = 1'b0;

    // icache-only load, accepted with tag 3
    nxt();
    ic_cmd = BUS_LOAD; ic_addr = 32'h100; m_resp = 4'd3;
    #1;
    chk("i_cmd", p_cmd, BUS_LOAD);
    chk("i_addr", p_addr, 32'h100);
    chk("i_resp", ic_resp, 3);
    chk("i_dresp", dc_resp, 0);
    chk("i_gnt", gnt_d, 0);
    chk("i_pdata", p_data, 64'hDEAD_BEEF_0123_4567);
    nxt();
    m_tag = 4'd3; m_data = 64'h1111_2222_3333_4444;
    #1;
    chk("i_itag", ic_tag, 3);
    chk("i_dtag", dc_tag, 0);
    chk("i_mdata", d_out, 64'h1111_2222_3333_4444);
    nxt();
    m_tag = 4'd3;
    #1;
    chk("i_freed", ic_tag, 0);

    // both request; dcache wins; rejected
    nxt();
    ic_cmd = BUS_LOAD; ic_addr = 32'h100;
    dc_cmd = BUS_LOAD; dc_addr = 32'h200;
    #1;
    chk("both_addr", p_addr, 32'h200);
    chk("both_gnt", gnt_d, 1);
    chk("both_iresp", ic_resp, 0);
    nxt();
    #1;
    chk("idle_cmd", p_cmd, BUS_NONE);
    chk("idle_addr", p_addr, 0);

    // store does not allocate
    nxt();
    dc_cmd = BUS_STORE; dc_addr = 32'h300; m_resp = 4'd7;
    dc_data = 64'hCAFE_0000_0000_0007;
    #1;
    chk("st_cmd", p_cmd, BUS_STORE);
    chk("st_dresp", dc_resp, 7);
    chk("st_pdata", p_data, 64'hCAFE_0000_0000_0007);
    nxt();
    m_tag = 4'd7;
    #1;
    chk("st_itag", ic_tag, 0);
    chk("st_dtag", dc_tag, 0);

    // flush: tag 5 goes stale, tag 6 allocated same cycle stays live
    nxt();
    ic_cmd = BUS_LOAD; ic_addr = 32'h140; m_resp = 4'd5;
    #1;
    chk("fl_resp5", ic_resp, 5);
    nxt();
    ic_cmd = BUS_LOAD; ic_addr = 32'h180; m_resp = 4'd6;
    ic_flush = 1'b1;
    nxt();
    m_tag = 4'd5;
    #1;
    chk("fl_itag5", ic_tag, 0);
    chk("fl_dtag5", dc_tag, 0);
    nxt();
    m_tag = 4'd6;
    #1;
    chk("fl_itag6", ic_tag, 6);
    nxt();
    m_tag = 4'd5;
    #1;
    chk("fl_5gone", ic_tag, 0);

    // return and realloc of tag 2 in one cycle
    nxt();
    ic_cmd = BUS_LOAD; ic_addr = 32'h1C0; m_resp = 4'd2;
    nxt();
    m_tag = 4'd2;
    dc_cmd = BUS_LOAD; dc_addr = 32'h240; m_resp = 4'd2;
    #1;
    chk("re_itag", ic_tag, 2);
    chk("re_dtag", dc_tag, 0);
    chk("re_dresp", dc_resp, 2);
    nxt();
    m_tag = 4'd2;
    #1;
    chk("re_dtag2", dc_tag, 2);
    chk("re_itag2", ic_tag, 0);

    // starvation: both pending, rejected each cycle
    for (int c = 1; c <= 8; c++) begin
      nxt();
      ic_cmd = BUS_LOAD; ic_addr = 32'h400;
      dc_cmd = BUS_LOAD; dc_addr = 32'h500;
      #1;
      chk($sformatf("sv_gnt%0d", c), gnt_d, 1);
    end
    nxt();
    ic_cmd = BUS_LOAD; ic_addr = 32'h400;
    dc_cmd = BUS_LOAD; dc_addr = 32'h500;
    #1;
`ifdef ARB_STARVE_GUARD_EN
    chk("sv_boost_gnt", gnt_d, 0);
    chk("sv_boost_addr", p_addr, 32'h400);
`else
    chk("sv_strict_gnt", gnt_d, 1);
    chk("sv_strict_addr", p_addr, 32'h500);
`endif
    nxt();
    ic_cmd = BUS_LOAD; ic_addr = 32'h400;
    dc_cmd = BUS_LOAD; dc_addr = 32'h500;
    #1;
    chk("sv_back_gnt", gnt_d, 1);

    nxt();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive cycles icache may be denied before it is boosted.
REQ-002 SHALL have parameter TAG_W, default 4, meaning the memory tag width (tag 0 = no tag).
REQ-003 SHALL have ports as follows; one clock; reset is asynchronous and active-high:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- icache_command  in  2  BUS_NONE or BUS_LOAD from icache.
- icache_addr  in  XLEN  icache request address.
- icache_flush  in  1  branch squash; discards outstanding icache fills.
- dcache_command  in  2  BUS_NONE, BUS_LOAD or BUS_STORE from dcache.
- dcache_addr  in  XLEN  dcache request address.
- dcache_data  in  64  dcache store data.
- mem2proc_response  in  TAG_W  memory accept tag (0 = rejected).
- mem2proc_data  in  64  memory return data.
- mem2proc_tag  in  TAG_W  memory return tag.
- proc2mem_command  out  2  command driven to memory.
- proc2mem_addr  out  XLEN  address driven to memory.
- proc2mem_data  out  64  store data driven to memory.
- icache_response  out  TAG_W  accept tag routed to icache.
- dcache_response  out  TAG_W  accept tag routed to dcache.
- icache_tag  out  TAG_W  return tag routed to icache.
- dcache_tag  out  TAG_W  return tag routed to dcache.
- mem_data_out  out  64  mem2proc_data, broadcast to both caches.
- grant_dcache  out  1  high when dcache owns the bus this cycle.

Function
REQ-004 SHALL select the requester combinationally in the same cycle; a request with command != BUS_NONE is pending.
REQ-005 SHALL use state DCACHE_PRI as follows: dcache wins if pending, otherwise icache.
REQ-006 SHALL use state ICACHE_BOOST as follows: icache wins if pending, otherwise dcache; the state SHALL return to DCACHE_PRI after one cycle.
REQ-007 SHALL increment starve_cnt (saturating) each cycle icache is pending and not granted, and SHALL clear it on any icache grant or when icache is idle.
REQ-008 SHALL move the state DCACHE_PRI->ICACHE_BOOST when starve_cnt == STARVE_LIMIT-1 and the icache is denied again.
REQ-009 SHALL drive proc2mem_command/addr from the winner; with no winner, proc2mem_command = BUS_NONE, addr = 0; proc2mem_data = dcache_data always.
REQ-010 SHALL route mem2proc_response to the winner's *_response output only; the loser SHALL see 0.
REQ-011 SHALL record owner (I/D) and valid in tag table entry [mem2proc_response] on a nonzero mem2proc_response for BUS_LOAD; BUS_STORE SHALL NOT allocate.
REQ-012 SHALL route a nonzero mem2proc_tag to icache_tag or dcache_tag per the owner when the entry is valid, and SHALL clear that entry; a return to an invalid entry SHALL output 0 to both.
REQ-013 SHALL, for an icache entry marked stale, suppress the return (icache_tag = 0) and free the entry.
REQ-014 SHALL, while icache_flush is high, mark all valid icache entries stale; entries allocated in the same cycle SHALL NOT be marked stale.
REQ-015 SHALL apply free-then-allocate when the same tag is returned and re-allocated in one cycle, leaving the entry valid with the new owner.
REQ-016 SHALL treat a rejected request (response 0) as follows: no allocation; the requester retries; starve_cnt still counts if the icache lost.

Reset
REQ-017 SHALL, while reset is asserted, asynchronously set state = DCACHE_PRI, starve_cnt = 0, and all tag entries invalid and not stale.
REQ-018 SHALL drive 0 on every registered-state-derived output during reset; a return tag arriving during reset SHALL be dropped.

Configuration
REQ-019 SHALL, with ARB_STARVE_GUARD_EN defined, implement REQ-006..REQ-008.
REQ-020 SHALL, with ARB_STARVE_GUARD_EN undefined, use strict dcache priority, omit starve_cnt and ICACHE_BOOST, and keep all other behaviour unchanged.

Structure
REQ-021 SHALL place the ARB_STATE enum, the TAG_ENTRY struct (valid, owner, stale) and the ARB_OWNER_I/ARB_OWNER_D constants in the shared sys_defs package.
REQ-022 SHALL implement the tag table as sub-module mem_tag_table (alloc, free, flush ports).

Verification
REQ-023 SHALL cover: icache LOAD 0x100 only, response 3 -> icache_response = 3, dcache_response = 0; later mem2proc_tag = 3 -> icache_tag = 3.
REQ-024 SHALL cover: dcache LOAD 0x200 and icache LOAD 0x100 in the same cycle -> proc2mem_addr = 0x200, grant_dcache = 1.
REQ-025 SHALL cover, with the guard enabled: dcache held pending 8 cycles with icache also pending -> in cycle 9 icache is granted and state returns to DCACHE_PRI.
REQ-026 SHALL cover: icache tag 5 outstanding, icache_flush pulsed, then mem2proc_tag = 5 -> icache_tag = 0 and entry 5 is freed.
REQ-027 SHALL cover: dcache STORE, response 7, then mem2proc_tag = 7 -> both *_tag outputs = 0.
REQ-028 SHALL cover: tag 2 returned while a new dcache LOAD gets response 2 in the same cycle -> old owner receives tag 2 and entry 2 becomes valid with owner D.
